// File: rtl/multicore_mem_arbiter_if.sv
// Bus between the cores, the arbiter and the single data memory.
// slave is the arbiter side; master is the cores-plus-memory side.
interface multicore_mem_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 17
);
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_we;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_end;
    logic [NUM_CORES-1:0]        core_grant;
    logic [NUM_CORES-1:0]        core_done;
    logic [DATA_W-1:0]           core_rdata;
    logic                        mem_en;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        all_done;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_end, mem_rdata,
        output core_grant, core_done, core_rdata, mem_en, mem_addr, mem_wdata, all_done
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_end, mem_rdata,
        input  core_grant, core_done, core_rdata, mem_en, mem_addr, mem_wdata, all_done
    );
endinterface

// File: rtl/multicore_mem_arbiter.sv
// Shares one data memory among NUM_CORES cores, one access per 3 cycles (ARB->ACCESS->RESP).
// Grant 1 cycle after a request seen in ARB; losing cores stay pending on core_req until granted.
module multicore_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 17,
    parameter int RR_MODE   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    multicore_mem_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {ARB, ACCESS, RESP} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     last_win_q;
    logic [NUM_CORES-1:0] grant_q;
    logic [NUM_CORES-1:0] done_q;
    logic [NUM_CORES-1:0] ended_q;
    logic                 mem_en_q;
    logic                 all_done_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [DATA_W-1:0]    rdata_q;

    logic [IDX_W-1:0]     win_d;
    logic                 win_vld_d;
    logic [IDX_W-1:0]     cand;
    int                   idx;

    logic [ADDR_W-1:0]    addr_a  [NUM_CORES];
    logic [DATA_W-1:0]    wdata_a [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign addr_a[i]  = bus.core_addr[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = bus.core_wdata[i*DATA_W +: DATA_W];
    end

    function automatic logic [NUM_CORES-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Scan from the lowest-priority slot upward so the last hit is the highest-priority requester.
    always_comb begin
        win_d     = '0;
        win_vld_d = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (RR_MODE != 0) begin
                idx = int'(last_win_q) + 1 + k;
                if (idx >= NUM_CORES) begin
                    idx = idx - NUM_CORES;
                end
            end else begin
                idx = k;
            end
            cand = IDX_W'(idx);
            if (bus.core_req[cand]) begin
                win_d     = cand;
                win_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            last_win_q  <= IDX_W'(NUM_CORES - 1);
            grant_q     <= '0;
            done_q      <= '0;
            ended_q     <= '0;
            mem_en_q    <= 1'b0;
            all_done_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            grant_q    <= '0;
            done_q     <= '0;
            mem_en_q   <= 1'b0;
            ended_q    <= ended_q | bus.core_end;
            all_done_q <= &ended_q;
            unique case (state_q)
                ARB: begin
                    if (win_vld_d) begin
                        state_q     <= ACCESS;
                        last_win_q  <= win_d;
                        grant_q     <= onehot(win_d);
                        mem_en_q    <= bus.core_we[win_d];
                        mem_addr_q  <= addr_a[win_d];
                        mem_wdata_q <= wdata_a[win_d];
                    end
                end
                ACCESS: begin
                    state_q <= RESP;
                    done_q  <= onehot(last_win_q);
                end
                RESP: begin
                    // Memory data for the address presented in ACCESS is valid now.
                    state_q <= ARB;
                    rdata_q <= bus.mem_rdata;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign bus.core_grant = grant_q;
    assign bus.core_done  = done_q;
    assign bus.core_rdata = rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.all_done   = all_done_q;
endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Bench for multicore_mem_arbiter: directed scenarios plus random traffic against a timing-rule model.
// Round-robin and fixed-priority instances share clock and reset.
module tb_multicore_mem_arbiter;
    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 17;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicore_mem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) rr_bus ();
    multicore_mem_arbiter_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) fp_bus ();

    multicore_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (rr_bus)
    );

    multicore_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (fp_bus)
    );

    logic [NC-1:0] req, we, cend, fp_req;
    logic [AW-1:0] addr  [NC];
    logic [DW-1:0] wdata [NC];

    assign rr_bus.core_req = req;
    assign rr_bus.core_we  = we;
    assign rr_bus.core_end = cend;
    always_comb begin
        rr_bus.core_addr  = '0;
        rr_bus.core_wdata = '0;
        for (int i = 0; i < NC; i++) begin
            rr_bus.core_addr[i*AW +: AW]  = addr[i];
            rr_bus.core_wdata[i*DW +: DW] = wdata[i];
        end
    end

    assign fp_bus.core_req   = fp_req;
    assign fp_bus.core_we    = '0;
    assign fp_bus.core_addr  = '0;
    assign fp_bus.core_wdata = '0;
    assign fp_bus.core_end   = '0;
    assign fp_bus.mem_rdata  = '0;

    // Synchronous-read data memory: data for an address appears one cycle after it is presented.
    logic [DW-1:0] dev_mem [0:(1<<AW)-1];
    logic [DW-1:0] dev_rd;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << AW); i++) dev_mem[i] <= '0;
            dev_rd <= '0;
        end else begin
            dev_rd <= dev_mem[rr_bus.mem_addr];
            if (rr_bus.mem_en) dev_mem[rr_bus.mem_addr] <= rr_bus.mem_wdata;
        end
    end
    assign rr_bus.mem_rdata = dev_rd;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [NC-1:0] v);
        idx_of = -1;
        for (int i = 0; i < NC; i++) if (v[i]) idx_of = i;
    endfunction

    // ---------------- reference model (timing rules, checked every cycle) ----------------
    logic          s_rst;
    logic [NC-1:0] s_req, s_we, s_end;
    logic [AW-1:0] s_addr  [NC];
    logic [DW-1:0] s_wdata [NC];
    logic [DW-1:0] ref_mem [int];
    int            cyc = 0, free_at = 0, done_at = -1, rdata_at = -1, alldone_at = -1;
    int            last = NC - 1, w = 0, c = 0;
    logic [NC-1:0] e_grant, e_done, ended_m;
    logic          e_en, e_all;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata, rd_val;

    initial begin
        forever begin
            @(posedge clk);
            s_rst = rst; s_req = req; s_we = we; s_end = cend;
            s_addr = addr; s_wdata = wdata;
            @(negedge clk);
            cyc++;
            if (s_rst) begin
                free_at = cyc + 1; last = NC - 1; done_at = -1; rdata_at = -1;
                e_grant = '0; e_done = '0; e_en = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
                ended_m = '0; alldone_at = -1;
                ref_mem.delete();
            end else begin
                e_grant = '0;
                e_en    = 1'b0;
                e_done  = (cyc == done_at) ? NC'(1) << w : '0;
                if (cyc == rdata_at) e_rdata = rd_val;
                if (cyc >= free_at && s_req != '0) begin
                    w = -1;
                    for (int k = 1; k <= NC; k++) begin
                        c = (last + k) % NC;
                        if (w < 0 && s_req[c]) w = c;
                    end
                    last    = w;
                    e_grant = NC'(1) << w;
                    e_en    = s_we[w];
                    e_addr  = s_addr[w];
                    e_wdata = s_wdata[w];
                    rd_val  = ref_mem.exists(int'(s_addr[w])) ? ref_mem[int'(s_addr[w])] : '0;
                    if (s_we[w]) ref_mem[int'(s_addr[w])] = s_wdata[w];
                    done_at  = cyc + 1;
                    rdata_at = cyc + 2;
                    free_at  = cyc + 3;
                end
                ended_m = ended_m | s_end;
                if (&ended_m && alldone_at < 0) alldone_at = cyc + 1;
            end
            e_all = (alldone_at >= 0) && (cyc >= alldone_at);
            check_eq("m_grant",    rr_bus.core_grant, e_grant);
            check_eq("m_done",     rr_bus.core_done,  e_done);
            check_eq("m_mem_en",   rr_bus.mem_en,     e_en);
            check_eq("m_mem_addr", rr_bus.mem_addr,   e_addr);
            check_eq("m_mem_wdat", rr_bus.mem_wdata,  e_wdata);
            check_eq("m_rdata",    rr_bus.core_rdata, e_rdata);
            check_eq("m_all_done", rr_bus.all_done,   e_all);
        end
    end

    // ---------------- stimulus ----------------
    // Cores drop their request on the edge after their grant.
    task automatic step();
        @(posedge clk);
        #1;
        cend = '0;
        for (int i = 0; i < NC; i++) begin
            if (rr_bus.core_grant[i]) req[i] = 1'b0;
            if (fp_bus.core_grant[i]) fp_req[i] = 1'b0;
        end
    endtask

    task automatic set_rr(input int core, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[core] = 1'b1; we[core] = wr; addr[core] = a; wdata[core] = d;
    endtask

    task automatic raise_all();
        for (int i = 0; i < NC; i++) begin
            if (!req[i] && !rr_bus.core_grant[i]) set_rr(i, 1'b0, AW'($urandom_range(0, 15)), '0);
        end
    endtask

    int   g_core [5];
    int   g_t    [5];
    int   gi;
    logic found;
    logic n2;

    initial begin
        rst = 1'b1; req = '0; we = '0; cend = '0; fp_req = '0;
        for (int i = 0; i < NC; i++) begin addr[i] = '0; wdata[i] = '0; end
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_grant",    rr_bus.core_grant, '0);
        check_eq("rst_done",     rr_bus.core_done,  '0);
        check_eq("rst_mem_en",   rr_bus.mem_en,     1'b0);
        check_eq("rst_mem_addr", rr_bus.mem_addr,   '0);
        check_eq("rst_rdata",    rr_bus.core_rdata, '0);
        check_eq("rst_all_done", rr_bus.all_done,   1'b0);

        // single write by core 2
        step(); rst = 1'b0;
        set_rr(2, 1'b1, 12'h005, 17'h1ABCD);
        step(); @(negedge clk);
        check_eq("wr_grant", rr_bus.core_grant, 4'b0100);
        check_eq("wr_en",    rr_bus.mem_en,     1'b1);
        check_eq("wr_addr",  rr_bus.mem_addr,   12'h005);
        check_eq("wr_data",  rr_bus.mem_wdata,  17'h1ABCD);
        step(); @(negedge clk);
        check_eq("wr_done",  rr_bus.core_done,  4'b0100);
        check_eq("wr_en_off", rr_bus.mem_en,    1'b0);
        step();

        // read back by core 1
        set_rr(1, 1'b0, 12'h005, '0);
        step(); @(negedge clk);
        check_eq("rd_grant", rr_bus.core_grant, 4'b0010);
        check_eq("rd_en",    rr_bus.mem_en,     1'b0);
        step(); @(negedge clk);
        check_eq("rd_done",  rr_bus.core_done,  4'b0010);
        step(); @(negedge clk);
        check_eq("rd_data",  rr_bus.core_rdata, 17'h1ABCD);

        // round-robin order from reset, all cores requesting
        rst = 1'b1; we = '0; req = '1;
        step(); rst = 1'b0;
        gi = 0;
        for (int t = 0; t < 13; t++) begin
            step(); raise_all();
            @(negedge clk);
            if (rr_bus.core_grant != '0 && gi < 5) begin
                g_core[gi] = idx_of(rr_bus.core_grant); g_t[gi] = t; gi++;
            end
        end
        check_eq("rr_count", gi, 5);
        check_eq("rr_first_t", g_t[0], 0);
        for (int k = 0; k < 5; k++) check_eq("rr_order", g_core[k], k % NC);
        for (int k = 1; k < 5; k++) check_eq("rr_spacing", g_t[k] - g_t[k-1], 3);

        // reset while core 2 is in its access cycle
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            step(); raise_all();
            @(negedge clk);
            if (rr_bus.core_grant == 4'b0100) found = 1'b1;
        end
        check_eq("mid_found", found, 1'b1);
        rst = 1'b1;
        step(); rst = 1'b0; raise_all();
        @(negedge clk);
        check_eq("mid_done",  rr_bus.core_done, '0);
        check_eq("mid_mem_en", rr_bus.mem_en,   1'b0);
        step(); @(negedge clk);
        check_eq("mid_done2",  rr_bus.core_done,  '0);
        check_eq("mid_next",   rr_bus.core_grant, 4'b0001);

        // all_done
        req = '0; rst = 1'b1;
        step(); rst = 1'b0;
        cend = 4'b0001; step(); @(negedge clk);
        check_eq("ad_after_1", rr_bus.all_done, 1'b0);
        cend = 4'b0100; step(); @(negedge clk);
        check_eq("ad_after_2", rr_bus.all_done, 1'b0);
        cend = 4'b1010; step(); @(negedge clk);
        check_eq("ad_after_3", rr_bus.all_done, 1'b0);
        step(); @(negedge clk);
        check_eq("ad_set",     rr_bus.all_done, 1'b1);
        repeat (3) step();
        @(negedge clk);
        check_eq("ad_sticky",  rr_bus.all_done, 1'b1);
        rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        check_eq("ad_reset",   rr_bus.all_done, 1'b0);

        // fixed priority: cores 1 and 3
        fp_req = 4'b1010;
        step(); @(negedge clk);
        check_eq("fp_first", fp_bus.core_grant, 4'b0010);
        step(); @(negedge clk);
        check_eq("fp_gap1",  fp_bus.core_grant, '0);
        step(); @(negedge clk);
        check_eq("fp_gap2",  fp_bus.core_grant, '0);
        step(); @(negedge clk);
        check_eq("fp_second", fp_bus.core_grant, 4'b1000);

        // fixed priority: core 2 re-requests and beats waiting core 3
        repeat (2) step();
        fp_req = 4'b1100; gi = 0; n2 = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (!fp_req[2] && !fp_bus.core_grant[2] && !n2) begin fp_req[2] = 1'b1; n2 = 1'b1; end
            @(negedge clk);
            if (fp_bus.core_grant != '0 && gi < 3) begin
                g_core[gi] = idx_of(fp_bus.core_grant); gi++;
            end
        end
        check_eq("fp_count", gi, 3);
        check_eq("fp_ord0", g_core[0], 2);
        check_eq("fp_ord1", g_core[1], 2);
        check_eq("fp_ord2", g_core[2], 3);

        // random traffic, end pulses and occasional resets
        req = '0; rst = 1'b1;
        step(); rst = 1'b0;
        for (int t = 0; t < 600; t++) begin
            step();
            for (int i = 0; i < NC; i++) begin
                if (!req[i] && !rr_bus.core_grant[i] && $urandom_range(0, 2) == 0)
                    set_rr(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            end
            if ($urandom_range(0, 19) == 0) cend[$urandom_range(0, NC - 1)] = 1'b1;
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/multicore_mem_arbiter.md
MULTICORE_MEM_ARBITER -- requirements
Module: multicore_mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, giving the number of processor cores sharing one data memory; legal range is 2..8.
REQ-002 The block SHALL have parameter ADDR_W, default 12, giving the data-memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 17, giving the data-memory word width.
REQ-004 The block SHALL have parameter RR_MODE, default 1; 1 selects round-robin arbitration and 0 selects fixed priority with the lowest index winning.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, width 1: synchronous active-high reset.
REQ-007 The block SHALL have port core_req, input, width NUM_CORES: per-core access request, held until granted.
REQ-008 The block SHALL have port core_we, input, width NUM_CORES: per-core write enable, qualified by core_req.
REQ-009 The block SHALL have port core_addr, input, width NUM_CORES*ADDR_W: flattened per-core address, with core i at bits [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port core_wdata, input, width NUM_CORES*DATA_W: flattened per-core write data.
REQ-011 The block SHALL have port core_end, input, width NUM_CORES: per-core end_process indication.
REQ-012 The block SHALL have port core_grant, output, width NUM_CORES: one-hot grant pulse.
REQ-013 The block SHALL have port core_done, output, width NUM_CORES: one-hot completion pulse.
REQ-014 The block SHALL have port core_rdata, output, width DATA_W: shared read-return data.
REQ-015 The block SHALL have port mem_en, output, width 1: data-memory write enable.
REQ-016 The block SHALL have port mem_addr, output, width ADDR_W: data-memory address.
REQ-017 The block SHALL have port mem_wdata, output, width DATA_W: data-memory write data.
REQ-018 The block SHALL have port mem_rdata, input, width DATA_W: data-memory read data, valid one cycle after the address is presented.
REQ-019 The block SHALL have port all_done, output, width 1: asserted when every core has ended.

Function
REQ-020 The FSM SHALL have three states, ARB, ACCESS and RESP, with transitions ARB->ACCESS when any core_req bit is 1, ACCESS->RESP unconditionally, and RESP->ARB unconditionally.
REQ-021 In ARB with core_req nonzero, the winner index, core_we, core_addr and core_wdata SHALL be latched on the edge that enters ACCESS.
REQ-022 With RR_MODE=1, the search SHALL start at (last_winner+1) mod NUM_CORES and wrap; the pointer SHALL update only when a grant is issued.
REQ-023 With RR_MODE=0, the lowest-indexed requesting core SHALL always win.
REQ-024 During ACCESS, core_grant[winner] SHALL be 1 for exactly one cycle, mem_addr SHALL equal the latched address, mem_wdata SHALL equal the latched data, and mem_en SHALL equal the latched we.
REQ-025 mem_en SHALL be 0 in every state other than ACCESS; mem_addr and mem_wdata SHALL hold their last values.
REQ-026 In RESP, core_rdata SHALL capture mem_rdata, for both reads and writes, and core_done[winner] SHALL pulse for one cycle.
REQ-027 Throughput SHALL be one access per 3 cycles; request-to-grant latency SHALL be 1 cycle when the arbiter is in ARB; a core SHALL drop core_req on the edge after its grant.
REQ-028 Requests from cores not granted SHALL be held pending and SHALL never be dropped or reordered by the block.
REQ-029 Each core_end bit SHALL set a sticky ended flag; all_done SHALL be registered and equal the AND of all flags, asserting one cycle after the last flag sets.
REQ-030 Requests from cores whose ended flag is set SHALL still be served.

Reset
REQ-031 While rst=1 on an edge, the FSM SHALL enter ARB, and core_grant, core_done, mem_en, all_done and the ended flags SHALL go to 0.
REQ-032 While rst=1 on an edge, mem_addr, mem_wdata and core_rdata SHALL go to 0, and the round-robin pointer SHALL go to NUM_CORES-1 so that core 0 is searched first.
REQ-033 Reset asserted in ACCESS or RESP SHALL abort the access with no core_done pulse, and mem_en SHALL be 0 in the following cycle.

Verification
REQ-034 The bench SHALL cover a single write: core 2 requests with we=1, addr 0x005, data 0x1ABCD -> core_grant=0100 one cycle later, mem_en=1 with addr 0x005 and data 0x1ABCD, and core_done=0100 on the next cycle.
REQ-035 The bench SHALL cover a read: core 1 reads addr 0x005 after that write, with memory returning 0x1ABCD -> core_rdata=0x1ABCD and core_done=0010.
REQ-036 The bench SHALL cover round-robin order: all 4 cores request continuously from reset with RR_MODE=1 -> grant order 0,1,2,3,0, with grants spaced 3 cycles apart.
REQ-037 The bench SHALL cover fixed priority: cores 1 and 3 request with RR_MODE=0 -> core 1 is granted first and core 3 is granted 3 cycles later.
REQ-038 The bench SHALL cover reset mid-operation: rst asserted during ACCESS -> no core_done pulse, mem_en=0 next cycle, and the next grant goes to core 0.
REQ-039 The bench SHALL cover all_done: core_end pulses 0001, 0100, 1010 on separate cycles -> all_done=1 exactly one cycle after the third pulse, and all_done stays 1 until reset.
